// File: rtl/mux_pipe.sv
// mux_pipe: registered N-way selector with one-hot decode, error count and 2-entry skid buffer
module mux_pipe #(
    parameter int WIDTH = 32,
    parameter int N = 5,
    parameter int SEL_W = 3,
    parameter logic [WIDTH-1:0] DFLT = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [N-1:0]       out_sel_oh,
    output logic               out_err,
    output logic [7:0]         err_cnt
);
    logic [WIDTH-1:0] new_data, main_data, skid_data;
    logic [N-1:0] new_oh, main_oh, skid_oh;
    logic new_err, main_err, skid_err, main_v, skid_v, acc, xfer;
    always_comb begin
        new_data = DFLT;
        new_oh = '0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                new_oh[k] = 1'b1;
                new_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end
    assign new_err = ~|new_oh;
    assign in_ready = !skid_v;
    assign acc = in_valid && in_ready;
    assign xfer = main_v && out_ready;
    assign out_valid = main_v;
    assign out_data = main_data;
    assign out_sel_oh = main_oh;
    assign out_err = main_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_data <= '0;
            main_oh <= '0;
            main_err <= 1'b0;
            skid_data <= '0;
            skid_oh <= '0;
            skid_err <= 1'b0;
            err_cnt <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            if (xfer || !main_v) begin
                main_v <= skid_v || acc;
                skid_v <= 1'b0;
                if (skid_v)
                    {main_data, main_oh, main_err} <= {skid_data, skid_oh, skid_err};
                else if (acc)
                    {main_data, main_oh, main_err} <= {new_data, new_oh, new_err};
            end else if (acc) begin
                skid_v <= 1'b1;
                {skid_data, skid_oh, skid_err} <= {new_data, new_oh, new_err};
            end
            if (acc && new_err && err_cnt != 8'hff)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed self-checking bench for mux_pipe
module tb_mux_pipe;
    localparam int WIDTH = 32, N = 5, SEL_W = 3;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_err;
    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel = '0;
    logic [WIDTH-1:0] out_data;
    logic [N-1:0] out_sel_oh;
    logic [7:0] err_cnt;
    int vectors = 0, miscompares = 0;

    mux_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel_oh(out_sel_oh), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (out_valid !== 0 || out_data !== 0 || out_sel_oh !== 0 || out_err !== 0 || err_cnt !== 0 || in_ready !== 1) begin
            miscompares++;
            $display("FAIL reset got v=%b d=%h oh=%b e=%b cnt=%0d rdy=%b exp all 0, rdy=1", out_valid, out_data, out_sel_oh, out_err, err_cnt, in_ready);
        end
        #3 rst_n = 1;
        step();
    endtask

    task automatic test_stream;
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_sel = SEL_W'(i);
            step();
            vectors++;
            if (out_valid !== 1 || out_data !== 32'h1000_0000 + i || out_sel_oh !== N'(1 << i) || out_err !== 0) begin
                miscompares++;
                $display("FAIL stream[%0d] got v=%b d=%h oh=%b e=%b exp v=1 d=%h oh=%b e=0", i, out_valid, out_data, out_sel_oh, out_err, 32'h1000_0000 + i, N'(1 << i));
            end
        end
        in_valid = 0;
        step();
        vectors++;
        if (out_valid !== 0) begin
            miscompares++;
            $display("FAIL stream_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_oob;
        logic [SEL_W-1:0] sels [2] = '{3'd5, 3'd7};
        out_ready = 1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1;
            in_sel = sels[i];
            step();
            vectors++;
            if (out_valid !== 1 || out_data !== 0 || out_sel_oh !== 0 || out_err !== 1) begin
                miscompares++;
                $display("FAIL oob[%0d] got v=%b d=%h oh=%b e=%b exp v=1 d=0 oh=0 e=1", i, out_valid, out_data, out_sel_oh, out_err);
            end
        end
        in_valid = 0;
        step();
        vectors++;
        if (err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL oob_cnt got %0d exp 2", err_cnt);
        end
    endtask

    task automatic test_stall;
        out_ready = 0;
        in_valid = 1;
        in_sel = 0;
        step();
        vectors++;
        if (out_data !== 32'h1000_0000 || in_ready !== 1) begin
            miscompares++;
            $display("FAIL stall_a got d=%h rdy=%b exp d=10000000 rdy=1", out_data, in_ready);
        end
        in_sel = 1;
        step();
        in_sel = 2;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1 || out_data !== 32'h1000_0000 || out_sel_oh !== 5'b00001 || in_ready !== 0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got v=%b d=%h oh=%b rdy=%b exp v=1 d=10000000 oh=00001 rdy=0", i, out_valid, out_data, out_sel_oh, in_ready);
            end
            if (i < 2) step();
        end
        out_ready = 1;
        step();
        vectors++;
        if (out_valid !== 1 || out_data !== 32'h1000_0001 || in_ready !== 1) begin
            miscompares++;
            $display("FAIL stall_b got v=%b d=%h rdy=%b exp v=1 d=10000001 rdy=1", out_valid, out_data, in_ready);
        end
        step();
        in_valid = 0;
        vectors++;
        if (out_valid !== 1 || out_data !== 32'h1000_0002) begin
            miscompares++;
            $display("FAIL stall_c got v=%b d=%h exp v=1 d=10000002", out_valid, out_data);
        end
        step();
        vectors++;
        if (out_valid !== 0) begin
            miscompares++;
            $display("FAIL stall_end got v=%b exp 0 (duplicate)", out_valid);
        end
    endtask

    task automatic test_flush;
        out_ready = 0;
        in_valid = 1;
        in_sel = 0;
        step();
        in_sel = 1;
        step();
        flush = 1;
        in_valid = 1;
        in_sel = 6;
        step();
        flush = 0;
        in_valid = 0;
        vectors++;
        if (out_valid !== 0 || in_ready !== 1 || err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL flush got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=2", out_valid, in_ready, err_cnt);
        end
        out_ready = 1;
        step();
        step();
        vectors++;
        if (out_valid !== 0 || err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL flush_ghost got v=%b cnt=%0d exp v=0 cnt=2", out_valid, err_cnt);
        end
    endtask

    task automatic test_sat;
        out_ready = 1;
        in_valid = 1;
        in_sel = 5;
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (err_cnt !== 8'd102) begin
            miscompares++;
            $display("FAIL sat_mid got %0d exp 102", err_cnt);
        end
        for (int i = 0; i < 200; i++) step();
        vectors++;
        if (err_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_top got %0d exp 255", err_cnt);
        end
        in_sel = 2;
        for (int i = 0; i < 4; i++) step();
        in_valid = 0;
        vectors++;
        if (err_cnt !== 8'd255 || out_data !== 32'h1000_0002 || out_err !== 0) begin
            miscompares++;
            $display("FAIL sat_hold got cnt=%0d d=%h e=%b exp cnt=255 d=10000002 e=0", err_cnt, out_data, out_err);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 0;
        in_valid = 1;
        in_sel = 0;
        step();
        in_sel = 1;
        step();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        vectors++;
        if (out_valid !== 0 || out_data !== 0 || out_sel_oh !== 0 || out_err !== 0 || err_cnt !== 0 || in_ready !== 1) begin
            miscompares++;
            $display("FAIL async_rst got v=%b d=%h oh=%b e=%b cnt=%0d rdy=%b exp all 0, rdy=1", out_valid, out_data, out_sel_oh, out_err, err_cnt, in_ready);
        end
        #2 rst_n = 1;
        step();
        out_ready = 1;
        in_valid = 1;
        in_sel = 3;
        step();
        in_valid = 0;
        vectors++;
        if (out_valid !== 1 || out_data !== 32'h1000_0003 || out_sel_oh !== 5'b01000) begin
            miscompares++;
            $display("FAIL async_rst_after got v=%b d=%h oh=%b exp v=1 d=10000003 oh=01000", out_valid, out_data, out_sel_oh);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_oob();
        test_stall();
        test_flush();
        test_sat();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised, registered N-way datapath selector; successor to the combinational 2/3/5-way muxes and 2-to-4 decoder in the MIPS datapath.
- Selects one of N WIDTH-bit inputs and emits the result with a one-hot decode of the select.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so pipeline stalls do not drop or duplicate words.
- Out-of-range selects return DFLT, raise an error flag and are counted.

Parameters:
- WIDTH, 32: data width per input and output.
- N, 5: number of inputs. Legal range 2..2^SEL_W.
- SEL_W, 3: select width.
- DFLT, 0: value output when the select is >= N.

Ports:
- clk  input  1: clock, rising edge.
- rst_n  input  1: asynchronous active-low reset.
- flush  input  1: synchronous clear of all buffered entries.
- in_valid  input  1: input word valid.
- in_ready  output  1: block can accept an input word.
- in_data  input  N*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W: index of the input to select.
- out_valid  output  1: output entry valid.
- out_ready  input  1: downstream accepts the output entry.
- out_data  output  WIDTH: selected word.
- out_sel_oh  output  N: one-hot of the select; all zero when the select is out of range.
- out_err  output  1: set when the select was >= N.
- err_cnt  output  8: saturating count of accepted out-of-range selects.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel_oh=0, out_err=0, err_cnt=0.
  - Both buffer entries empty; in_ready=1.
- Accept and output transfer:
  - An input is accepted when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready.
- Select evaluation, done at accept time:
  - data = in_sel<N ? input[in_sel] : DFLT.
  - oh = in_sel<N ? (1<<in_sel) : 0.
  - err = (in_sel>=N).
  - The {data, oh, err} triple is stored as one entry.
- Latency and throughput:
  - Accept in cycle t gives out_valid in cycle t+1 when the buffer was empty.
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Buffer structure: main register (drives the outputs) plus one skid register.
  - Both empty: an accepted entry goes to main.
  - Main full, output transfer this cycle, accept this cycle: the new entry replaces main.
  - Main full, no transfer, accept: the entry goes to skid.
  - Transfer with skid full: skid moves to main and skid empties.
- in_ready is registered: in_ready = !skid_full after the edge. An accept with in_ready=1 never overflows.
- Stall: while out_valid && !out_ready, out_data, out_sel_oh and out_err stay stable.
- Ordering: entries leave strictly in acceptance order.
- Flush:
  - Next edge: both entries empty, out_valid=0, in_ready=1.
  - An input presented in the flush cycle is discarded and is not counted in err_cnt.
  - Flush wins over a simultaneous accept or transfer.
- err_cnt:
  - Increments by 1 on each accepted entry with err=1.
  - Saturates at 255.
  - Cleared only by reset; flush does not clear it.
- Mid-operation reset: asynchronous. All state returns to reset values immediately, regardless of handshake state.
- No combinational path from out_ready to in_ready.
- in_data and in_sel are sampled only on accept.

Test Plan:
- WIDTH=32, N=5, out_ready=1. Stream in_sel=0..4 with input k = 0x1000_0000+k, one per cycle → out_data 0x1000_0000..0x1000_0004 in consecutive cycles, each 1 cycle after accept. out_sel_oh 00001..10000, out_err=0.
- in_sel=5, then 7 → out_data=0 (DFLT), out_sel_oh=0, out_err=1 for each entry; err_cnt=2.
- Hold out_ready=0, drive in_valid=1 with words A,B,C:
  - A and B are accepted; in_ready=0 from the cycle after B; C is held off.
  - out_data stays A.
  - Raise out_ready: outputs are A, then B, then C with no loss or duplicate.
- Two entries buffered, flush=1 together with in_valid=1 → next cycle out_valid=0, in_ready=1. The flushed input never appears. err_cnt is unchanged even if that input had in_sel=6.
- 300 accepted out-of-range selects → err_cnt reaches 255 and holds. Entries with in_sel<N leave it unchanged.
- Deassert rst_n mid-stall with both entries full → outputs go to 0 immediately; in_ready=1. After release, the first accept appears 1 cycle later.
